// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB565 pixel type, 640x480@60 timing and frame size.
package vga_pkg;
  typedef logic [15:0] pixel_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
endpackage

// File: rtl/vga_frame_reader_if.sv
// Avalon-MM burst read bus between the frame reader (master) and memory (slave).
interface vga_frame_reader_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [6:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (output avm_address, avm_read, avm_burstcount,
                  input  avm_waitrequest, avm_readdata, avm_readdatavalid);
  modport slave  (input  avm_address, avm_read, avm_burstcount,
                  output avm_waitrequest, avm_readdata, avm_readdatavalid);
endinterface

// File: rtl/vga_pixel_fifo.sv
// Show-ahead pixel FIFO with synchronous clear; head reads as 0 while empty.
module vga_pixel_fifo import vga_pkg::pixel_t; #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pixel_t                 data_i,
  output pixel_t                 data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  assign empty_o = (cnt_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/vga_frame_reader.sv
// Fetches a frame over Avalon-MM bursts into a pixel FIFO feeding the VGA sink.
// Double buffering is enabled by defining VGA_FRAME_READER_DOUBLE_BUFFER_EN.
module vga_frame_reader import vga_pkg::pixel_t; #(
  parameter logic [31:0] FRAME_BASE     = 32'h0000_0000,
  parameter logic [31:0] FRAME_BASE_ALT = 32'h0009_6000,
  parameter int          FRAME_PIXELS   = vga_pkg::FRAME_PIXELS,
  parameter int          BURST_LEN      = 16,
  parameter int          FIFO_DEPTH     = 64
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  frame_start,
  input  logic  frame_hold,
  output pixel_t vga_data,
  output logic  vga_valid,
  input  logic  vga_ready,
  vga_frame_reader_if.master avm,
  input  logic  swap_req,
  output logic  swap_ack,
  output logic  busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(FRAME_PIXELS + 1);

  state_e        state_q;
  logic          start_q, rd_q, swap_ack_q;
  logic [CW-1:0] issued_q;
  logic [OW-1:0] outst_q;
  logic [31:0]   addr_q;
  logic [6:0]    bc_q;

  logic [OW-1:0] fifo_cnt;
  logic          fifo_empty, push, pop, accept, room, frame_done, start_rise, go, rv_cnt;
  logic [31:0]   remain, start_base;
  logic [6:0]    bsize;
  logic          do_swap;

  assign accept     = rd_q && !avm.avm_waitrequest;
  assign remain     = 32'(FRAME_PIXELS) - 32'(issued_q);
  assign bsize      = (remain < 32'(BURST_LEN)) ? remain[6:0] : 7'(BURST_LEN);
  // Credit check: words already buffered plus words still owed must leave room for the burst.
  assign room       = (32'(fifo_cnt) + 32'(outst_q) + 32'(bsize)) <= 32'(FIFO_DEPTH);
  assign frame_done = 32'(issued_q) == 32'(FRAME_PIXELS);
  assign start_rise = frame_start && !start_q;
  assign go         = (state_q == IDLE) && start_rise && !frame_hold;
  assign rv_cnt     = avm.avm_readdatavalid && (outst_q != '0);
  assign push       = rv_cnt && (state_q != FLUSH) && !frame_hold;
  assign pop        = vga_valid && vga_ready;
  assign vga_valid  = !fifo_empty && (state_q != FLUSH);

`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
  logic active_q, pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      pend_q   <= 1'b0;
    end else if (go) begin
      active_q <= active_q ^ pend_q;
      pend_q   <= swap_req;
    end else if (swap_req) begin
      pend_q   <= 1'b1;
    end
  end

  assign do_swap    = pend_q;
  assign start_base = (active_q ^ pend_q) ? FRAME_BASE_ALT : FRAME_BASE;
`else
  logic unused_swap;
  assign unused_swap = ^{swap_req, FRAME_BASE_ALT};
  assign do_swap     = 1'b0;
  assign start_base  = FRAME_BASE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      issued_q   <= '0;
      outst_q    <= '0;
      addr_q     <= FRAME_BASE;
      rd_q       <= 1'b0;
      bc_q       <= '0;
      swap_ack_q <= 1'b0;
    end else begin
      start_q    <= frame_start;
      swap_ack_q <= 1'b0;
      outst_q    <= outst_q + (accept ? OW'(bc_q) : '0) - (rv_cnt ? OW'(1) : '0);
      // A pending request is held through waitrequest even once a flush starts.
      if (accept) begin
        rd_q     <= 1'b0;
        bc_q     <= '0;
        issued_q <= issued_q + CW'(bc_q);
        addr_q   <= addr_q + {24'b0, bc_q, 1'b0};
      end
      case (state_q)
        IDLE:
          if (go) begin
            state_q    <= FETCH;
            issued_q   <= '0;
            addr_q     <= start_base;
            swap_ack_q <= do_swap;
          end
        FETCH:
          if (frame_done) state_q <= DRAIN;
          else if (!rd_q && room && !frame_hold) begin
            rd_q <= 1'b1;
            bc_q <= bsize;
          end
        DRAIN:
          if (outst_q == '0) state_q <= IDLE;
        FLUSH:
          if (!frame_hold && !rd_q && outst_q == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (frame_hold) state_q <= FLUSH;
    end
  end

  vga_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (frame_hold),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (avm.avm_readdata),
    .data_o  (vga_data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_burstcount = bc_q;
  assign swap_ack           = swap_ack_q;
  assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: 72-pixel frame (bursts 16,16,16,16,8) against a word-indexed memory model.
module tb_vga_frame_reader;
  import vga_pkg::pixel_t;

  localparam int NPIX = 72;
`ifdef VGA_FRAME_READER_DOUBLE_BUFFER_EN
  localparam logic [31:0] E2_ADDR = 32'h0009_6000;
  localparam int          E2_ACK  = 1;
  localparam logic [15:0] E2_PIX  = 16'hB000;
`else
  localparam logic [31:0] E2_ADDR = 32'h0;
  localparam int          E2_ACK  = 0;
  localparam logic [15:0] E2_PIX  = 16'h0000;
`endif

  logic   clk = 0, reset = 1, frame_start = 0, frame_hold = 0, vga_ready = 1, swap_req = 0;
  logic   vga_valid, swap_ack, busy;
  pixel_t vga_data;

  vga_frame_reader_if avm_if ();

  vga_frame_reader #(
    .FRAME_BASE(32'h0), .FRAME_BASE_ALT(32'h0009_6000),
    .FRAME_PIXELS(NPIX), .BURST_LEN(16), .FIFO_DEPTH(64)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_hold(frame_hold),
    .vga_data(vga_data), .vga_valid(vga_valid), .vga_ready(vga_ready),
    .avm(avm_if), .swap_req(swap_req), .swap_ack(swap_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory slave: word at byte address A reads as (A>>1)[15:0]; returns one word per cycle.
  logic [15:0] rq [$];
  logic [31:0] acc_addr [$];
  int          acc_bc [$];
  int          acc_n = 0, rv_n = 0, ack_n = 0, stall_cnt = 0, stall_idx = -1;
  logic        rv_en = 1, stall_mon = 0;

  assign avm_if.avm_waitrequest = avm_if.avm_read && (acc_n == stall_idx) && (stall_cnt < 10);

  always @(posedge clk) begin
    if (reset) begin
      rq.delete();
      avm_if.avm_readdatavalid <= 1'b0;
      avm_if.avm_readdata      <= '0;
    end else begin
      if (avm_if.avm_read && !avm_if.avm_waitrequest) begin
        for (int i = 0; i < int'(avm_if.avm_burstcount); i++)
          rq.push_back(16'((avm_if.avm_address >> 1) + 32'(i)));
        acc_addr.push_back(avm_if.avm_address);
        acc_bc.push_back(int'(avm_if.avm_burstcount));
        acc_n <= acc_n + 1;
      end
      if (avm_if.avm_read && avm_if.avm_waitrequest) stall_cnt <= stall_cnt + 1;
      if (rv_en && rq.size() > 0) begin
        avm_if.avm_readdata      <= rq.pop_front();
        avm_if.avm_readdatavalid <= 1'b1;
      end else begin
        avm_if.avm_readdatavalid <= 1'b0;
      end
      if (avm_if.avm_readdatavalid) rv_n <= rv_n + 1;
      if (swap_ack) ack_n <= ack_n + 1;
    end
  end

  int          n_chk = 0, n_fail = 0, pix_n = 0;
  logic [15:0] pix_base = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, return just after the next posedge.
  task automatic tick();
    @(negedge clk);
    if (vga_valid && vga_ready) begin
      chk("pix", vga_data, pix_base + 16'(pix_n));
      pix_n++;
    end
    if (stall_mon && avm_if.avm_read && avm_if.avm_waitrequest) begin
      chk("stall_addr", avm_if.avm_address, 32'h40);
      chk("stall_bc", avm_if.avm_burstcount, 16);
    end
    if (frame_hold) chk("hold_valid", vga_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    frame_start = 1;
    repeat (3) tick();
    frame_start = 0;
    tick();
  endtask

  task automatic wait_done(input string tag, input int npix);
    int n = 0;
    while ((busy || pix_n < npix) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, n < 3000, 1);
  endtask

  task automatic chk_bursts(input int a0);
    chk("nburst", acc_n - a0, 5);
    for (int i = 0; i < 5; i++)
      if (a0 + i < acc_addr.size()) begin
        chk("baddr", acc_addr[a0 + i], 32'(i) * 32'h20);
        chk("bcount", acc_bc[a0 + i], (i < 4) ? 16 : 8);
      end
  endtask

  initial begin
    int a0, r0, k0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", vga_valid, 0);
    chk("rst_data", vga_data, 0);
    chk("rst_read", avm_if.avm_read, 0);
    chk("rst_addr", avm_if.avm_address, 0);
    chk("rst_bc", avm_if.avm_burstcount, 0);
    chk("rst_ack", swap_ack, 0);
    reset = 0;
    tick();

    // Full frame, free-running sink
    a0 = acc_n; pix_n = 0; pix_base = 16'h0;
    start_frame();
    wait_done("a_done", NPIX);
    chk_bursts(a0);
    chk("a_npix", pix_n, NPIX);
    chk("a_busy", busy, 0);

    // Stalled sink: FIFO credit limits fetch to four bursts
    vga_ready = 0; a0 = acc_n; pix_n = 0;
    start_frame();
    repeat (500) tick();
    chk("b_nburst_stall", acc_n - a0, 4);
    chk("b_valid", vga_valid, 1);
    vga_ready = 1;
    wait_done("b_done", NPIX);
    chk_bursts(a0);
    chk("b_npix", pix_n, NPIX);

    // Waitrequest held for 10 cycles on the third burst
    a0 = acc_n; pix_n = 0; stall_idx = acc_n + 2; stall_mon = 1;
    start_frame();
    wait_done("c_done", NPIX);
    stall_mon = 0;
    chk("c_stalls", stall_cnt, 10);
    chk_bursts(a0);
    chk("c_npix", pix_n, NPIX);

    // Hold with two bursts in flight: their data is discarded
    rv_en = 0; a0 = acc_n; r0 = rv_n; pix_n = 0; n = 0;
    frame_start = 1;
    while (acc_n - a0 < 2 && n < 50) begin
      tick();
      n++;
    end
    frame_hold = 1;
    frame_start = 0;
    chk("d_inflight", acc_n - a0, 2);
    repeat (5) tick();
    chk("d_busy", busy, 1);
    rv_en = 1;
    repeat (60) tick();
    chk("d_discard", rv_n - r0, 32);
    chk("d_nburst", acc_n - a0, 2);
    chk("d_npix", pix_n, 0);
    frame_hold = 0;
    wait_done("d_idle", 0);
    chk("d_busy_end", busy, 0);

    // Restart from FRAME_BASE; request a swap mid-frame
    a0 = acc_n; pix_n = 0; pix_base = 16'h0; k0 = ack_n;
    start_frame();
    repeat (10) tick();
    swap_req = 1;
    tick();
    swap_req = 0;
    wait_done("e1_done", NPIX);
    chk("e1_addr", (acc_addr.size() > a0) ? acc_addr[a0] : 32'hFFFF_FFFF, 32'h0);
    chk("e1_ack", ack_n - k0, 0);
    chk("e1_npix", pix_n, NPIX);

    // Following frame picks up the swapped base when double buffering is built in
    a0 = acc_n; pix_n = 0; pix_base = E2_PIX; k0 = ack_n;
    start_frame();
    wait_done("e2_done", NPIX);
    chk("e2_addr", (acc_addr.size() > a0) ? acc_addr[a0] : 32'hFFFF_FFFF, E2_ADDR);
    chk("e2_ack", ack_n - k0, E2_ACK);
    chk("e2_npix", pix_n, NPIX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
